// File: rtl/queue_reader.sv
// Consumer-side client for the message queue: strobes read_ack, samples the
// queue after a settle window, decodes opcode/x/y and hands it downstream.
module queue_reader #(
  parameter int MSG_W         = 24,
  parameter int OP_W          = 4,
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int NUM_OPS       = 6,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int POLL_GAP      = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic             q_read_ack,
  input  logic [MSG_W-1:0] q_read,
  input  logic             q_read_en,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [OP_W-1:0]  msg_op,
  output logic [X_W-1:0]   msg_x,
  output logic [Y_W-1:0]   msg_y,
  output logic             bad_op,
  output logic             busy,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] empty_count,
  output logic [CNT_W-1:0] bad_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_SETTLE, S_SAMPLE, S_HOLD, S_BACKOFF
  } state_t;

  localparam int TMAX_PS = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TMAX    = (TMAX_PS > POLL_GAP) ? TMAX_PS : POLL_GAP;
  localparam int TW      = $clog2(TMAX + 1);

  // SETTLE and BACKOFF last one cycle less than their parameter because the
  // SAMPLE cycle and the following IDLE cycle complete the respective window.
  localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [TW-1:0] GAP_LAST    = TW'((POLL_GAP > 1) ? POLL_GAP - 2 : 0);
  localparam logic [OP_W:0] OPS_LIM     = (OP_W + 1)'(NUM_OPS);

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_cnt;
  logic             r_ack, r_valid, r_bad;
  logic [OP_W-1:0]  r_op;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [CNT_W-1:0] r_rx, r_empty, r_badc;

  logic [OP_W-1:0]  w_op;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic             w_legal, w_load, w_bad, w_empty;

  assign w_op    = q_read[MSG_W-1 -: OP_W];
  assign w_x     = q_read[X_W+Y_W-1 -: X_W];
  assign w_y     = q_read[Y_W-1:0];
  assign w_legal = ({1'b0, w_op} < OPS_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_state_nxt = S_PULSE;
      S_PULSE:   if (r_cnt == PULSE_LAST)
                   w_state_nxt = (SETTLE_CYCLES > 1) ? S_SETTLE : S_SAMPLE;
      S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        if (!q_read_en)   w_state_nxt = (POLL_GAP > 1) ? S_BACKOFF : S_IDLE;
        else if (w_legal) w_state_nxt = S_HOLD;
        else              w_state_nxt = S_IDLE;
      end
      S_HOLD:    if (msg_ready) w_state_nxt = S_IDLE;
      S_BACKOFF: if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_bad   = 1'b0;
    w_empty = 1'b0;
    busy    = (r_state != S_IDLE);
    if (r_state == S_SAMPLE) begin
      w_load  =  q_read_en &  w_legal;
      w_bad   =  q_read_en & ~w_legal;
      w_empty = ~q_read_en;
    end
  end

  // Window counter restarts on every state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    r_cnt <= '0;
    else if (w_state_nxt != r_state) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  // Strobe and valid are registered so the queue never sees a decode glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_bad   <= 1'b0;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_rx    <= '0;
      r_empty <= '0;
      r_badc  <= '0;
    end else begin
      r_ack   <= (w_state_nxt == S_PULSE);
      r_valid <= (w_state_nxt == S_HOLD);
      r_bad   <= w_bad;
      if (w_load) begin
        r_op <= w_op;
        r_x  <= w_x;
        r_y  <= w_y;
      end
      if (w_load  && r_rx    != '1) r_rx    <= r_rx + 1'b1;
      if (w_empty && r_empty != '1) r_empty <= r_empty + 1'b1;
      if (w_bad   && r_badc  != '1) r_badc  <= r_badc + 1'b1;
    end
  end

  assign q_read_ack  = r_ack;
  assign msg_valid   = r_valid;
  assign msg_op      = r_op;
  assign msg_x       = r_x;
  assign msg_y       = r_y;
  assign bad_op      = r_bad;
  assign rx_count    = r_rx;
  assign empty_count = r_empty;
  assign bad_count   = r_badc;

endmodule
